// File: rtl/mem_access_unit.sv
// Memory access unit: turns a single load/store request into word-aligned
// memory cycles. Sub-word stores do a read-modify-write. Misaligned requests
// finish immediately with an alignment fault and never touch memory.
module mem_access_unit #(
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

    state_t      state, next_state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_wr;
    logic        req_sext;
    logic        req_misalign;
    logic [2:0]  rd_cnt;

    logic        in_word, in_half, in_aligned;
    logic        req_word, req_half;
    logic        rd_last;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Decode the incoming request (size 11 behaves as a word) and its alignment
    always_comb begin
        in_word    = (size == 2'b00) || (size == 2'b11);
        in_half    = (size == 2'b01);
        in_aligned = 1'b1;
        if (in_word) begin
            in_aligned = (addr[1:0] == 2'b00);
        end else if (in_half) begin
            in_aligned = ~addr[0];
        end
    end

    // Decode the latched request and pick the addressed lane out of the read word
    always_comb begin
        req_word    = (req_size == 2'b00) || (req_size == 2'b11);
        req_half    = (req_size == 2'b01);
        rd_last     = (rd_cnt == LAST_CNT);
        lane_byte   = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
        lane_half   = mem_rdata[{req_addr[1], 4'b0000} +: 16];
        load_value  = mem_rdata;
        merged_word = mem_rdata;
        if (req_word) begin
            load_value  = mem_rdata;
            merged_word = req_wdata;
        end else if (req_half) begin
            load_value = {{16{req_sext & lane_half[15]}}, lane_half};
            merged_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end else begin
            load_value = {{24{req_sext & lane_byte[7]}}, lane_byte};
            merged_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end
    end

    // Next-state selection; start is only looked at while idle
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!in_aligned) begin
                        next_state = DONE;
                    end else if (mem_wr && in_word) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD: begin
                if (rd_last) begin
                    next_state = req_wr ? WR : DONE;
                end
            end
            WR:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status and memory-control outputs follow directly from the current state
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        mem_we   = (state == WR);
        misalign = (state == DONE) && req_misalign;
        mem_addr = 32'h0;
        if ((state == RD) || (state == WR)) begin
            mem_addr = {req_addr[31:2], 2'b00};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the request and its alignment verdict when it is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr     <= 32'h0;
            req_wdata    <= 32'h0;
            req_size     <= 2'b00;
            req_wr       <= 1'b0;
            req_sext     <= 1'b0;
            req_misalign <= 1'b0;
        end else if ((state == IDLE) && start) begin
            req_addr     <= addr;
            req_wdata    <= wdata;
            req_size     <= size;
            req_wr       <= mem_wr;
            req_sext     <= sign_ext;
            req_misalign <= ~in_aligned;
        end
    end

    // Read-latency counter: runs only in RD and wraps back to zero on the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 3'd0;
        end else if ((state == RD) && !rd_last) begin
            rd_cnt <= rd_cnt + 3'd1;
        end else begin
            rd_cnt <= 3'd0;
        end
    end

    // Load result register; only a completing load updates it
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 32'h0;
        end else if ((state == RD) && rd_last && !req_wr) begin
            data_out <= load_value;
        end
    end

    // Store data register: word stores take wdata directly, sub-word stores the merged read word
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_wdata <= 32'h0;
        end else if ((state == IDLE) && start && in_aligned && mem_wr && in_word) begin
            mem_wdata <= wdata;
        end else if ((state == RD) && rd_last && req_wr) begin
            mem_wdata <= merged_word;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vectors with known results, random
// transactions checked against a behavioural model through a scoreboard queue,
// plus start-while-busy and reset-abort scenarios.
module tb_mem_access_unit;

    localparam int LAT = 2;

    typedef struct {
        int          lat;
        logic [31:0] dout;
        logic        mis;
        int          we;
        logic [31:0] wdat;
        logic [31:0] waddr;
        logic [31:0] rdaddr;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        misalign;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    exp_t        exp_q[$];
    logic [31:0] ref_dout;

    int          obs_lat;
    int          obs_we;
    logic        obs_timeout;
    logic [31:0] obs_dout;
    logic        obs_mis;
    logic [31:0] obs_wdat;
    logic [31:0] obs_waddr;
    logic [31:0] obs_rdaddr;
    logic [31:0] obs_done_addr;
    logic        obs_idle_done;

    mem_access_unit #(.READ_LAT(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mem_wr(mem_wr),
        .size(size),
        .sign_ext(sign_ext),
        .addr(addr),
        .wdata(wdata),
        .mem_rdata(mem_rdata),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .data_out(data_out),
        .busy(busy),
        .done(done),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour of one request, independent of the DUT structure
    function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sx,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input logic [31:0] prev);
        exp_t        e;
        int          nb;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        nb     = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
        mask   = (nb == 4) ? 32'hFFFF_FFFF : (nb == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        sh     = int'(a[1:0]) * 8;
        e.lat  = 0;
        e.dout = prev;
        e.mis  = 1'b0;
        e.we   = 0;
        e.wdat = 32'h0;
        e.waddr  = a & 32'hFFFF_FFFC;
        e.rdaddr = 32'h0;
        if ((int'(a[1:0]) % nb) != 0) begin
            e.lat = 1;
            e.mis = 1'b1;
        end else if (!wr) begin
            v = (rd >> sh) & mask;
            if (sx && (nb < 4) && v[8*nb-1]) v = v | ~mask;
            e.dout   = v;
            e.lat    = LAT + 1;
            e.rdaddr = a & 32'hFFFF_FFFC;
        end else if (nb == 4) begin
            e.lat  = 2;
            e.we   = 1;
            e.wdat = wd;
        end else begin
            e.lat    = LAT + 2;
            e.we     = 1;
            e.wdat   = (rd & ~(mask << sh)) | ((wd & mask) << sh);
            e.rdaddr = a & 32'hFFFF_FFFC;
        end
        return e;
    endfunction

    // Drive one request for a single cycle and record what the DUT does until done, bounded
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        int t0;
        mem_wr    = wr;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        wdata     = wd;
        mem_rdata = rd;
        start     = 1'b1;
        t0        = cyc;
        obs_we        = 0;
        obs_lat       = 0;
        obs_timeout   = 1'b1;
        obs_dout      = 32'h0;
        obs_mis       = 1'b0;
        obs_wdat      = 32'h0;
        obs_waddr     = 32'h0;
        obs_rdaddr    = 32'h0;
        obs_done_addr = 32'h0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_we) begin
                obs_we++;
                obs_wdat  = mem_wdata;
                obs_waddr = mem_addr;
            end
            if (busy && !mem_we && !done) obs_rdaddr = mem_addr;
            if (done) begin
                obs_lat       = cyc - t0;
                obs_dout      = data_out;
                obs_mis       = misalign;
                obs_done_addr = mem_addr;
                obs_timeout   = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        obs_idle_done = done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL reset data_out: got %h expected 0", data_out); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset mem_addr: got %h expected 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset mem_we: got %b expected 0", mem_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy (start held): got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL reset misalign: got %b expected 0", misalign); end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t vecs[12];
        exp_t e;
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, '{LAT+1, 32'hDEADBEEF, 1'b0, 0, 32'h0,        32'h0,   32'h100}};
        vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h103, 32'h0,        32'h80123456, '{LAT+1, 32'hFFFFFF80, 1'b0, 0, 32'h0,        32'h0,   32'h100}};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h103, 32'h0,        32'h80123456, '{LAT+1, 32'h00000080, 1'b0, 0, 32'h0,        32'h0,   32'h100}};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h11223344, '{LAT+2, 32'h00000080, 1'b0, 1, 32'hABCD3344, 32'h200, 32'h200}};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h101, 32'h0,        32'hDEADBEEF, '{1,     32'h00000080, 1'b1, 0, 32'h0,        32'h0,   32'h0}};
        vecs[5]  = '{1'b1, 2'b00, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,        '{2,     32'h00000080, 1'b0, 1, 32'hCAFEF00D, 32'h300, 32'h0}};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h106, 32'h0,        32'h80017FFF, '{LAT+1, 32'hFFFF8001, 1'b0, 0, 32'h0,        32'h0,   32'h104}};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h105, 32'h0,        32'h80017FFF, '{1,     32'hFFFF8001, 1'b1, 0, 32'h0,        32'h0,   32'h0}};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h401, 32'h12345678, 32'hAABBCCDD, '{LAT+2, 32'hFFFF8001, 1'b0, 1, 32'hAABB78DD, 32'h400, 32'h400}};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h10C, 32'h0,        32'h01020304, '{LAT+1, 32'h01020304, 1'b0, 0, 32'h0,        32'h0,   32'h10C}};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h10E, 32'h1,        32'h0,        '{1,     32'h01020304, 1'b1, 0, 32'h0,        32'h0,   32'h0}};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h203, 32'hFFFF,     32'h0,        '{1,     32'h01020304, 1'b1, 0, 32'h0,        32'h0,   32'h0}};
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(vecs[i].e);
            applyStimulus(vecs[i].wr, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd, vecs[i].rd);
            e = exp_q.pop_front();
            n_tests++; if (obs_timeout) begin n_fail++; $display("[TB] FAIL dir%0d timeout: no done within bound", i); end
            n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("[TB] FAIL dir%0d latency: got %0d expected %0d", i, obs_lat, e.lat); end
            n_tests++; if (obs_dout !== e.dout) begin n_fail++; $display("[TB] FAIL dir%0d data_out: got %h expected %h", i, obs_dout, e.dout); end
            n_tests++; if (obs_mis !== e.mis) begin n_fail++; $display("[TB] FAIL dir%0d misalign: got %b expected %b", i, obs_mis, e.mis); end
            n_tests++; if (obs_we !== e.we) begin n_fail++; $display("[TB] FAIL dir%0d mem_we pulses: got %0d expected %0d", i, obs_we, e.we); end
            n_tests++; if (obs_rdaddr !== e.rdaddr) begin n_fail++; $display("[TB] FAIL dir%0d read mem_addr: got %h expected %h", i, obs_rdaddr, e.rdaddr); end
            n_tests++; if (obs_done_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL dir%0d mem_addr in DONE: got %h expected 0", i, obs_done_addr); end
            n_tests++; if (obs_idle_done !== 1'b0) begin n_fail++; $display("[TB] FAIL dir%0d done width: got %b expected 0 after pulse", i, obs_idle_done); end
            if (e.we != 0) begin
                n_tests++; if (obs_wdat !== e.wdat) begin n_fail++; $display("[TB] FAIL dir%0d mem_wdata: got %h expected %h", i, obs_wdat, e.wdat); end
                n_tests++; if (obs_waddr !== e.waddr) begin n_fail++; $display("[TB] FAIL dir%0d write mem_addr: got %h expected %h", i, obs_waddr, e.waddr); end
            end
        end
        ref_dout = vecs[11].e.dout;
    endtask

    task automatic test_random();
        exp_t        e;
        logic        wr, sx;
        logic [1:0]  sz;
        logic [31:0] a, wd, rd;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            wd = $urandom;
            rd = $urandom;
            e  = model(wr, sz, sx, a, wd, rd, ref_dout);
            ref_dout = e.dout;
            exp_q.push_back(e);
            applyStimulus(wr, sz, sx, a, wd, rd);
            e = exp_q.pop_front();
            n_tests++; if (obs_timeout) begin n_fail++; $display("[TB] FAIL rnd%0d timeout: no done within bound", i); end
            n_tests++; if (obs_lat !== e.lat) begin n_fail++; $display("[TB] FAIL rnd%0d latency: got %0d expected %0d", i, obs_lat, e.lat); end
            n_tests++; if (obs_dout !== e.dout) begin n_fail++; $display("[TB] FAIL rnd%0d data_out: got %h expected %h", i, obs_dout, e.dout); end
            n_tests++; if (obs_mis !== e.mis) begin n_fail++; $display("[TB] FAIL rnd%0d misalign: got %b expected %b", i, obs_mis, e.mis); end
            n_tests++; if (obs_we !== e.we) begin n_fail++; $display("[TB] FAIL rnd%0d mem_we pulses: got %0d expected %0d", i, obs_we, e.we); end
            n_tests++; if (obs_rdaddr !== e.rdaddr) begin n_fail++; $display("[TB] FAIL rnd%0d read mem_addr: got %h expected %h", i, obs_rdaddr, e.rdaddr); end
            if (e.we != 0) begin
                n_tests++; if (obs_wdat !== e.wdat) begin n_fail++; $display("[TB] FAIL rnd%0d mem_wdata: got %h expected %h", i, obs_wdat, e.wdat); end
                n_tests++; if (obs_waddr !== e.waddr) begin n_fail++; $display("[TB] FAIL rnd%0d write mem_addr: got %h expected %h", i, obs_waddr, e.waddr); end
            end
        end
    endtask

    task automatic test_start_held();
        int          dones;
        int          done_at;
        logic        idle_busy;
        logic        next_busy;
        logic        second_done;
        mem_wr    = 1'b0;
        size      = 2'b00;
        sign_ext  = 1'b0;
        addr      = 32'h180;
        mem_rdata = 32'h5555AAAA;
        start     = 1'b1;
        dones     = 0;
        done_at   = 0;
        idle_busy = 1'b1;
        next_busy = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (done && (k <= LAT + 2)) begin
                dones++;
                done_at = k;
            end
            if (k == LAT + 2) idle_busy = busy;
            if (k == LAT + 3) next_busy = busy;
        end
        start = 1'b0;
        mem_rdata = 32'h0F0F0F0F;
        second_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                second_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++; if (dones !== 1) begin n_fail++; $display("[TB] FAIL held_start done count: got %0d expected 1", dones); end
        n_tests++; if (done_at !== LAT + 1) begin n_fail++; $display("[TB] FAIL held_start done latency: got %0d expected %0d", done_at, LAT + 1); end
        n_tests++; if (idle_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL held_start idle after done: busy got %b expected 0", idle_busy); end
        n_tests++; if (next_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL held_start re-accept: busy got %b expected 1", next_busy); end
        n_tests++; if (second_done !== 1'b1) begin n_fail++; $display("[TB] FAIL held_start second done: got %b expected 1", second_done); end
        n_tests++; if (data_out !== 32'h0F0F0F0F) begin n_fail++; $display("[TB] FAIL held_start second data_out: got %h expected 0f0f0f0f", data_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int   late_done;
        int   late_we;
        logic we_seen;
        mem_wr   = 1'b1;
        size     = 2'b00;
        sign_ext = 1'b0;
        addr     = 32'h500;
        wdata    = 32'h13579BDF;
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        we_seen = mem_we;
        reset   = 1'b1;
        @(negedge clk);
        n_tests++; if (we_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL abort WR reached: mem_we got %b expected 1", we_seen); end
        n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL abort mem_we: got %b expected 0", mem_we); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort done: got %b expected 0", done); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL abort mem_addr: got %h expected 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL abort mem_wdata: got %h expected 0", mem_wdata); end
        n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL abort data_out: got %h expected 0", data_out); end
        reset     = 1'b0;
        late_done = 0;
        late_we   = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) late_done++;
            if (mem_we) late_we++;
        end
        n_tests++; if (late_done !== 0) begin n_fail++; $display("[TB] FAIL abort late done pulses: got %0d expected 0", late_done); end
        n_tests++; if (late_we !== 0) begin n_fail++; $display("[TB] FAIL abort late mem_we cycles: got %0d expected 0", late_we); end
    endtask

    initial begin
        ref_dout = 32'h0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter READ_LAT, default 2: memory read latency in cycles, legal range 1..7.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 mem_wr  input  1  0 = load, 1 = store.
REQ-006 size  input  2  00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-007 sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-008 addr  input  32  byte address from the IorD address mux output.
REQ-009 wdata  input  32  store data; low byte/half used for sub-word stores.
REQ-010 mem_rdata  input  32  word read from memory.
REQ-011 mem_addr  output  32  word-aligned memory address.
REQ-012 mem_wdata  output  32  word written to memory.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 data_out  output  32  memory data register (load result).
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 misalign  output  1  alignment-fault flag, valid while done=1.

Function
REQ-018 States SHALL be IDLE, RD, WR, DONE.
REQ-019 Byte lane k (k = addr[1:0]) SHALL occupy bits [8k+7:8k]; the halfword at addr[1]=h SHALL occupy bits [16h+15:16h].
REQ-020 In IDLE with start=1, the unit SHALL latch addr, size, mem_wr, sign_ext and wdata, and check alignment: word needs addr[1:0]=00, half needs addr[0]=0, byte always aligned.
REQ-021 Misaligned request SHALL go IDLE->DONE with misalign=1; no memory access and no mem_we pulse; data_out unchanged.
REQ-022 Aligned load or sub-word store SHALL go IDLE->RD; aligned word store SHALL go IDLE->WR.
REQ-023 mem_addr SHALL equal {latched_addr[31:2],2'b00} in RD and WR, and 0 in IDLE and DONE.
REQ-024 RD SHALL last exactly READ_LAT cycles, counted by an internal counter; mem_rdata SHALL be sampled on the last RD edge.
REQ-025 Load exit from RD: data_out SHALL be loaded with the selected lane, extended to 32 bits per sign_ext (word: unmodified), then go to DONE.
REQ-026 Sub-word store exit from RD: the merged word (mem_rdata with the addressed lane replaced by the low byte/half of wdata) SHALL be registered into mem_wdata, then go to WR.
REQ-027 For a word store, mem_wdata SHALL be latched wdata.
REQ-028 WR SHALL last one cycle with mem_we=1, then go to DONE; mem_we SHALL be 0 in every other state.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE; misalign SHALL be 0 whenever done=0.
REQ-030 start while busy=1 SHALL be ignored and not queued; start in the DONE cycle SHALL also be ignored.
REQ-031 Latency, with start sampled at edge N: misaligned -> done in cycle N+1; word store -> N+2; load -> N+READ_LAT+1; sub-word store -> N+READ_LAT+2.
REQ-032 data_out SHALL hold its value between loads; stores SHALL NOT modify it.

Reset
REQ-033 With reset=1 at a clock edge, the unit SHALL set state=IDLE, counter=0, and data_out, mem_addr, mem_wdata, mem_we, busy, done, misalign all to 0.
REQ-034 Reset asserted mid-operation SHALL abort the request: a pending WR SHALL NOT issue mem_we and done SHALL NOT pulse.
REQ-035 reset SHALL take priority over start in the same cycle.

Verification
REQ-036 Word load addr=0x100, mem_rdata=0xDEADBEEF, READ_LAT=2 -> done at N+3, data_out=0xDEADBEEF, mem_addr=0x100 during RD.
REQ-037 Byte load addr=0x103, sign_ext=1, mem_rdata=0x80123456 -> data_out=0xFFFFFF80; with sign_ext=0 -> 0x00000080.
REQ-038 Half store addr=0x202, wdata=0x0000ABCD, mem_rdata=0x11223344 -> single mem_we pulse, mem_wdata=0xABCD3344, mem_addr=0x200, done at N+4.
REQ-039 Word load addr=0x101 -> done and misalign high at N+1, mem_we never asserted, data_out unchanged.
REQ-040 Word store issued, reset asserted during WR cycle -> mem_we deasserted that edge onward, no done pulse, all outputs 0, busy=0.
REQ-041 start held high through a whole load -> exactly one transaction and one done pulse; a new request is accepted only in the first IDLE cycle after DONE.
